// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage owning the program counter and the IF/ID register.
// Drives readAddress to instruction memory and registers the returned word with its PC.
// Handles stall, branch/jump redirect with a one-bubble flush, and end-of-program halt.
// Optional feature macro: BOUNDS_CHECK_EN adds the HALT state and the window comparison
// against MEM_WORDS*4; without it, halted is tied low and the pc runs freely.

module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_WORDS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic [31:0] instruction,
    output logic [31:0] readAddress,
    output logic [31:0] pcOut,
    output logic [31:0] instructionOut,
    output logic        valid,
    output logic        halted
);

`ifdef BOUNDS_CHECK_EN
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetchState_t;

    localparam logic [31:0] FETCH_LIMIT = 32'(MEM_WORDS * 4);
`else
    typedef enum logic [0:0] {
        FETCH = 1'b0
    } fetchState_t;
`endif

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic [31:0] alignedTarget;

    // Sequential pc increment and word-aligned redirect address.
    assign nextPc        = pc + 32'd4;
    assign alignedTarget = branchTarget & ~32'd3;
    assign readAddress   = pc;

`ifdef BOUNDS_CHECK_EN
    logic haltedReg;
    logic targetOutOfRange;
    logic nextOutOfRange;

    // Window checks: a redirect or a sequential step leaving the loaded program halts fetch.
    assign targetOutOfRange = (alignedTarget >= FETCH_LIMIT);
    assign nextOutOfRange   = (nextPc >= FETCH_LIMIT);
    assign halted           = haltedReg;

    // Fetch state machine: reset, then redirect, then halt check under stall, then normal fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc             <= RESET_PC;
            pcOut          <= 32'd0;
            instructionOut <= 32'd0;
            valid          <= 1'b0;
            haltedReg      <= 1'b0;
            state          <= FETCH;
        end else if (branchTaken) begin
            pc             <= alignedTarget;
            pcOut          <= 32'd0;
            instructionOut <= 32'd0;
            valid          <= 1'b0;
            if (targetOutOfRange) begin
                state     <= HALT;
                haltedReg <= 1'b1;
            end else begin
                state     <= FETCH;
                haltedReg <= 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        instructionOut <= instruction;
                        pcOut          <= pc;
                        valid          <= 1'b1;
                        pc             <= nextPc;
                        if (nextOutOfRange) begin
                            state     <= HALT;
                            haltedReg <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    valid          <= 1'b0;
                    instructionOut <= 32'd0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
`else
    assign halted = 1'b0;

    // Fetch state machine without bounds checking: reset, then redirect, then stall, then fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc             <= RESET_PC;
            pcOut          <= 32'd0;
            instructionOut <= 32'd0;
            valid          <= 1'b0;
            state          <= FETCH;
        end else if (branchTaken) begin
            pc             <= alignedTarget;
            pcOut          <= 32'd0;
            instructionOut <= 32'd0;
            valid          <= 1'b0;
            state          <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        instructionOut <= instruction;
                        pcOut          <= pc;
                        valid          <= 1'b1;
                        pc             <= nextPc;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test of instruction_fetch with a small combinational
// instruction memory. Words 0xA0..0xA5 live at byte addresses 0..20; anything else
// returns 0xDEAD in the upper half and the low address half below it.

module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] instruction;
    logic [31:0] readAddress;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        valid;
    logic        halted;

    int compareCount;
    int mismatchCount;

    instruction_fetch #(
        .RESET_PC (32'd0),
        .MEM_WORDS(6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branchTaken   (branchTaken),
        .branchTarget  (branchTarget),
        .instruction   (instruction),
        .readAddress   (readAddress),
        .pcOut         (pcOut),
        .instructionOut(instructionOut),
        .valid         (valid),
        .halted        (halted)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] memRead(input logic [31:0] addr);
        if (addr < 32'd24) begin
            return 32'hA0 + (addr >> 2);
        end
        return {16'hDEAD, addr[15:0]};
    endfunction

    // Instruction memory answers in the same cycle.
    assign instruction = memRead(readAddress);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] expPc, input logic [31:0] expInstr,
                             input logic expValid, input logic [31:0] expAddr, input logic expHalted);
        checkOutput({tag, ".pcOut"}, pcOut, expPc);
        checkOutput({tag, ".instr"}, instructionOut, expInstr);
        checkOutput({tag, ".valid"}, {31'd0, valid}, {31'd0, expValid});
        checkOutput({tag, ".addr"}, readAddress, expAddr);
        checkOutput({tag, ".halted"}, {31'd0, halted}, {31'd0, expHalted});
    endtask

    // Drive one cycle of inputs, take the rising edge, then settle before sampling.
    task automatic applyStimulus(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
        reset        = rst;
        stall        = stl;
        branchTaken  = br;
        branchTarget = tgt;
        @(posedge clock);
        #1;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        branchTaken   = 1'b0;
        branchTarget  = 32'd0;

        $display("[TB] reset and sequential fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkIfId("reset", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("fetch0", 32'd0, 32'hA0, 1'b1, 32'd4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("fetch4", 32'd4, 32'hA1, 1'b1, 32'd8, 1'b0);

        $display("[TB] two stalled cycles at pc 8");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkIfId("stall1", 32'd4, 32'hA1, 1'b1, 32'd8, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkIfId("stall2", 32'd4, 32'hA1, 1'b1, 32'd8, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("resume", 32'd8, 32'hA2, 1'b1, 32'd12, 1'b0);

        $display("[TB] misaligned branch during stall");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h6);
        checkIfId("branch", 32'd0, 32'd0, 1'b0, 32'd4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("target", 32'd4, 32'hA1, 1'b1, 32'd8, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("run8", 32'd8, 32'hA2, 1'b1, 32'd12, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("run12", 32'd12, 32'hA3, 1'b1, 32'd16, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("run16", 32'd16, 32'hA4, 1'b1, 32'd20, 1'b0);

`ifdef BOUNDS_CHECK_EN
        $display("[TB] end-of-program halt");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("last20", 32'd20, 32'hA5, 1'b1, 32'd24, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("haltBubble", 32'd20, 32'd0, 1'b0, 32'd24, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            checkOutput("haltAddr", readAddress, 32'd24);
            checkOutput("haltFlag", {31'd0, halted}, 32'd1);
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("farBranch.halted", {31'd0, halted}, 32'd1);
        checkOutput("farBranch.valid", {31'd0, valid}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
        checkIfId("restart", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("restart0", 32'd0, 32'hA0, 1'b1, 32'd4, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("rehalt.halted", {31'd0, halted}, 32'd1);
`else
        $display("[TB] free-running past the program window");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("run20", 32'd20, 32'hA5, 1'b1, 32'd24, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("run24", 32'd24, 32'hDEAD0018, 1'b1, 32'd28, 1'b0);

        $display("[TB] pc wrap at top of address space");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkIfId("wrapBranch", 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("wrapFetch", 32'hFFFF_FFFC, 32'hDEADFFFC, 1'b1, 32'd0, 1'b0);
`endif

        $display("[TB] reset with stall and branch asserted");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h10);
        checkIfId("midReset", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkIfId("postReset", 32'd0, 32'hA0, 1'b1, 32'd4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
